// File: rtl/riscy_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller: FSM states,
// opcode constants and the datapath mux / ALU control encodings.
package riscy_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH, LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALUControl is {sub/arith bit, funct3}; ADD and SUB/CMP are the fixed points.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h8;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_BU = 2'b10;
  localparam logic [1:0] IMM_J  = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] immsrc_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH, OP_LUI: return IMM_BU;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_aludec.sv
// ALU operation decoder for register and immediate arithmetic instructions.
// Shifts-right with funct7 set select the arithmetic variant in I-type too.
module aludec
  import riscy_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [3:0] alucontrol
);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alucontrol = {1'b0, funct3};
    if (op == OP_RTYPE || funct3 == 3'b101) alucontrol = {funct7, funct3};
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V control FSM with branch-condition logic.
// Define MC_CONTROL_MEMWAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_control
  import riscy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       pc_w, mem_w, ir_w, reg_w, ill;
  logic       mem_go, taken;
  logic [3:0] alu_dec;

`ifdef MC_CONTROL_MEMWAIT_EN
  assign mem_go = mem_ready;
`else
  wire unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  aludec u_aludec (
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .alucontrol (alu_dec)
  );

  // flags = {N, Z, C, V}
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = flags[2];
      3'b001:  taken = !flags[2];
      3'b100:  taken = flags[3] ^ flags[0];
      3'b101:  taken = !(flags[3] ^ flags[0]);
      3'b110:  taken = !flags[1];
      3'b111:  taken = flags[1];
      default: taken = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        ResultSrc = RES_ALURESULT;
        ALUSrcB   = SRCB_FOUR;
        ir_w      = mem_go;
        pc_w      = mem_go;
        if (mem_go) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = BRANCH;
          OP_LUI:            state_d = LUI;
          default: begin
            ill     = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_go) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = mem_go;
        if (mem_go) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = alu_dec;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_w    = 1'b1;
        state_d = ALUWB;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = ALU_SUB;
        pc_w       = taken;
        state_d    = FETCH;
      end
      LUI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are masked while reset is held so FETCH's writes cannot fire during reset.
  assign PCWrite  = pc_w  & rst_n;
  assign MemWrite = mem_w & rst_n;
  assign IRWrite  = ir_w  & rst_n;
  assign RegWrite = reg_w & rst_n;
  assign illegal  = ill   & rst_n;
  assign ImmSrc   = immsrc_of(op);

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: op  input  7 | funct3  input  3 | funct7  input  1  fields of the latched instruction register.
REQ-004 SHALL have port: flags  input  4  ALU flags {N,Z,C,V} at bits [3],[2],[1],[0].
REQ-005 SHALL have port: mem_ready  input  1  memory completion strobe; used only when MC_CONTROL_MEMWAIT_EN is defined.
REQ-006 SHALL have outputs: PCWrite 1, AdrSrc 1, MemWrite 1, IRWrite 1, RegWrite 1, ResultSrc 2, ALUSrcA 2, ALUSrcB 2, ImmSrc 2, ALUControl 4.
REQ-007 SHALL have output: illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, LUI; outputs depend on state only, except PCWrite in BRANCH.
REQ-009 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00 (PC), ALUSrcB=10 (+4), ALUControl=4'h0, ResultSrc=10, PCWrite=1; next DECODE.
REQ-010 DECODE: ALUSrcA=01 (oldPC), ALUSrcB=01 (imm), ALUControl=4'h0 (branch target); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BRANCH, 0110111->LUI, else FETCH with illegal=1.
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=4'h0; next MEMREAD if op=0000011, else MEMWRITE.
REQ-012 MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1 -> FETCH; MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
REQ-013 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; ALUControl from aludec; both -> ALUWB (ResultSrc=00, RegWrite=1) -> FETCH.
REQ-014 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=4'h0, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=4'h8, ResultSrc=00; PCWrite = taken -> FETCH; taken: beq Z, bne !Z, blt N^V, bge !(N^V), bltu !C, bgeu C, funct3 010/011 never.
REQ-016 LUI: ImmSrc=10, ALUSrcA=10, ALUSrcB=01, ALUControl=4'h0 (rs1=x0 assumed by datapath) -> ALUWB.
REQ-017 ImmSrc SHALL be decoded from op in every state: S 01, B/U 10 per encoding table in package, J 11, else 00.
REQ-018 All outputs not listed for a state SHALL be 0; PCWrite, MemWrite, RegWrite, IRWrite never X.
REQ-019 Cycle counts (no wait): branch 3, R/I/store/jal/lui 4, load 5.

Reset
REQ-020 rst_n low SHALL force state FETCH immediately, asynchronously, mid-instruction included; first post-reset edge performs a fetch.
REQ-021 During reset all write enables and illegal SHALL be 0; multi-bit outputs SHALL hold FETCH values.

Configuration
REQ-022 MC_CONTROL_MEMWAIT_EN defined: FETCH, MEMREAD, MEMWRITE SHALL hold state and hold outputs until mem_ready=1; PCWrite/IRWrite/MemWrite SHALL assert only in the mem_ready cycle of that state.
REQ-023 MC_CONTROL_MEMWAIT_EN undefined: mem_ready ignored, each such state lasts exactly one cycle.

Structure
REQ-024 Package riscy_pkg SHALL hold the state enum, opcode constants, ALUControl codes (ADD 4'h0, SUB/CMP 4'h8) and ImmSrc/ResultSrc/ALUSrc encodings.
REQ-025 Sub-module aludec SHALL map (op, funct3, funct7) to ALUControl for EXECR/EXECI; mc_control holds FSM and branch-condition logic.

Verification
REQ-026 Reset mid-MEMREAD (rst_n low) -> state FETCH same cycle, RegWrite=0; after release first edge IRWrite=1, PCWrite=1.
REQ-027 op=0000011 load, no wait -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 in cycle 5 only, ResultSrc=01.
REQ-028 op=1100011, funct3=100, flags=4'b1000 -> PCWrite=1 in cycle 3; flags=4'b1001 -> PCWrite=0.
REQ-029 op=1111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no write enables.
REQ-030 MEMWAIT_EN, op=0100011, mem_ready low 3 cycles in MEMWRITE -> MemWrite=0 for 3 cycles, 1 on ready cycle, then FETCH.
